// File: rtl/sram_controller.sv
// sram_controller: turns one 32-bit MEM-stage load/store into two back-to-back
// 16-bit accesses on an asynchronous SRAM (low half first, then high half).
// The pipeline stalls on ~ready while an access is in flight.
module sram_controller #(
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   output logic [1:0]  dbg_state
);

   // Request/ready handshake: a request (wr_en | rd_en) seen in IDLE is taken
   // at that clock edge and its address/data are latched; ready stays low from
   // that cycle until the DONE cycle. A request held through DONE is not taken
   // until the following IDLE cycle. wr_en wins when both are high.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              is_wr_q, is_wr_d;
   logic [16:0]       waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;

   logic [31:0]       off;
   logic              last_wait;
   logic              active;
   logic              half_sel;
   logic              drive_dq;
   logic [15:0]       dq_out;
   logic              unused_off_bits;

   // Offset into the SRAM window; wraps modulo 2^32, and only bits [18:2]
   // select the word, so anything beyond 512 KiB wraps silently.
   assign off             = address - 32'(BASE_ADDR);
   assign unused_off_bits = ^{off[31:19], off[1:0]};
   assign last_wait       = (cnt_q == CNT_LAST);

   // Next-state, wait counter, request latch and read-data capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      is_wr_d = is_wr_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (wr_en | rd_en) begin
               is_wr_d = wr_en;
               waddr_d = off[18:2];
               wdata_d = wdata;
               cnt_d   = '0;
               state_d = S_LOW;
            end
         end
         S_LOW: begin
            if (last_wait) begin
               cnt_d   = '0;
               state_d = S_HIGH;
               if (!is_wr_q) begin
                  rdata_d[15:0] = SRAM_DQ;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_HIGH: begin
            if (last_wait) begin
               cnt_d   = '0;
               state_d = S_DONE;
               if (!is_wr_q) begin
                  rdata_d[31:16] = SRAM_DQ;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         is_wr_q <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         is_wr_q <= is_wr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Bus outputs decoded from state so reset drops the write strobe at once.
   always_comb begin
      active    = (state_q == S_LOW) || (state_q == S_HIGH);
      half_sel  = (state_q == S_HIGH);
      drive_dq  = active && is_wr_q;
      dq_out    = half_sel ? wdata_q[31:16] : wdata_q[15:0];
      SRAM_ADDR = active ? {waddr_q, half_sel} : 18'd0;
      SRAM_WE_N = !drive_dq;
      ready     = ((state_q == S_IDLE) && !(wr_en | rd_en)) || (state_q == S_DONE);
   end

   assign SRAM_DQ   = drive_dq ? dq_out : 16'hzzzz;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;
   assign rdata     = rdata_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: table of accesses run cycle by cycle against an
// SRAM behavioural model, plus hand-written reset-abort and idle sequences.
module tb_sram_controller;

   localparam int W    = 2;
   localparam int BASE = 1024;
   localparam int NV   = 17;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [17:0] exp_lo;
      logic [31:0] exp_rd;
      logic        chain;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   wire  [15:0] SRAM_DQ;
   logic [17:0] SRAM_ADDR;
   logic        SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
   logic [1:0]  dbg_state;

   logic [15:0] mem [0:(1<<18)-1];
   logic        sram_model_en;
   wire         model_oe = sram_model_en && SRAM_WE_N && !SRAM_OE_N && !SRAM_CE_N;

   logic [31:0] exp_q[$];
   logic [31:0] last_rdata;
   int          n_checks;
   int          n_pass;
   vec_t        vecs [NV];

   sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
      .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
      .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
      .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
      .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
      .SRAM_WE_N(SRAM_WE_N), .dbg_state(dbg_state)
   );

   // Asynchronous SRAM model: drives the bus on reads, stores on write strobe.
   assign SRAM_DQ = model_oe ? mem[SRAM_ADDR] : 16'hzzzz;

   always @(posedge clk) begin
      if (!SRAM_WE_N && !SRAM_CE_N) begin
         mem[SRAM_ADDR] <= SRAM_DQ;
      end
   end

   // Clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One complete access, checked every cycle from request to DONE.
   task automatic run_access(input vec_t v, input vec_t nx);
      logic        is_wr;
      logic        hi;
      logic [31:0] e;
      is_wr = v.wr;
      @(posedge clk); #1;
      wr_en   = v.wr;
      rd_en   = v.rd;
      address = v.addr;
      wdata   = v.wd;
      if (!v.wr && v.rd) exp_q.push_back(v.exp_rd);
      @(negedge clk);
      check("c0_ready", ready, 0);
      check("c0_state_idle", dbg_state, 0);
      for (int c = 1; c <= 2*W+1; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            wr_en   = 1'b0;
            rd_en   = 1'b0;
            address = ~v.addr;
            wdata   = ~v.wd;
         end
         if (c == 2*W+1 && v.chain) begin
            wr_en   = nx.wr;
            rd_en   = nx.rd;
            address = nx.addr;
            wdata   = nx.wd;
         end
         @(negedge clk);
         if (c <= 2*W) begin
            hi = (c > W);
            check("sram_addr", SRAM_ADDR, v.exp_lo | 18'(hi));
            check("we_n", SRAM_WE_N, !is_wr);
            check("ready_busy", ready, 0);
            check("state_busy", dbg_state, hi ? 2 : 1);
            if (is_wr) check("dq_wr", SRAM_DQ, hi ? v.wd[31:16] : v.wd[15:0]);
         end else begin
            check("ready_done", ready, 1);
            check("state_done", dbg_state, 3);
            if (is_wr) begin
               check("rdata_kept_on_write", rdata, last_rdata);
            end else if (exp_q.size() == 0) begin
               check("scoreboard_empty", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("rdata", rdata, e);
               last_rdata = e;
            end
         end
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic rd, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] exp_rd);
      vec_t        v;
      logic [31:0] off;
      off      = addr - 32'(BASE);
      v.wr     = wr;
      v.rd     = rd;
      v.addr   = addr;
      v.wd     = wd;
      v.exp_lo = {off[18:2], 1'b0};
      v.exp_rd = exp_rd;
      v.chain  = 1'b0;
      return v;
   endfunction

   initial begin
      logic [31:0] ra;
      logic [31:0] rw;
      vec_t        v;
      n_checks      = 0;
      n_pass        = 0;
      last_rdata    = '0;
      sram_model_en = 1'b1;
      rst           = 1'b0;
      wr_en         = 1'b0;
      rd_en         = 1'b0;
      address       = '0;
      wdata         = '0;

      // Hand-picked vectors with literal expected SRAM word addresses.
      vecs[0] = mk(1, 0, 1024, 32'hDEADBEEF, 0);   vecs[0].exp_lo = 18'h00000;
      vecs[1] = mk(0, 1, 1024, 32'h0, 32'hDEADBEEF); vecs[1].exp_lo = 18'h00000;
      vecs[2] = mk(1, 0, 1028, 32'h12345678, 0);   vecs[2].exp_lo = 18'h00002;
      vecs[2].chain = 1'b1;
      vecs[3] = mk(0, 1, 1028, 32'h0, 32'h12345678); vecs[3].exp_lo = 18'h00002;
      vecs[4] = mk(1, 1, 1040, 32'hCAFEF00D, 0);   vecs[4].exp_lo = 18'h00008;
      vecs[5] = mk(0, 1, 1040, 32'h0, 32'hCAFEF00D); vecs[5].exp_lo = 18'h00008;
      vecs[6] = mk(1, 0, 1024 + 32'h7FFFC, 32'h0BADF00D, 0); vecs[6].exp_lo = 18'h3FFFE;
      vecs[7] = mk(0, 1, 1020, 32'h0, 32'h0BADF00D); vecs[7].exp_lo = 18'h3FFFE;
      vecs[8] = mk(1, 0, 1032, 32'h11112222, 0);   vecs[8].exp_lo = 18'h00004;
      // Random write/read-back pairs, kept clear of the low words used above.
      for (int i = 0; i < 4; i++) begin
         ra = 32'(BASE) + (32'($urandom_range(16, 65535)) << 2);
         rw = $urandom;
         vecs[9 + 2*i]  = mk(1, 0, ra, rw, 0);
         vecs[10 + 2*i] = mk(0, 1, ra, $urandom, rw);
      end

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_we_n", SRAM_WE_N, 1);
      check("rst_addr", SRAM_ADDR, 0);
      check("rst_rdata", rdata, 0);
      check("rst_state", dbg_state, 0);
      check("rst_ties", {SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}, 0);
      rst = 1'b1;

      for (int i = 0; i < NV; i++) begin
         run_access(vecs[i], vecs[(i + 1 < NV) ? i + 1 : i]);
      end

      // Reset during the HIGH phase of a store: low half lands, high half must not.
      @(posedge clk); #1;
      wr_en = 1'b1; address = 1032; wdata = 32'hAAAA5555;
      @(negedge clk);
      check("abort_c0_ready", ready, 0);
      for (int c = 1; c <= W + 1; c++) begin
         @(posedge clk); #1;
         wr_en = 1'b0; address = 32'h0; wdata = 32'h0;
         @(negedge clk);
         check("abort_we_n", SRAM_WE_N, 0);
         check("abort_addr", SRAM_ADDR, (c > W) ? 18'h5 : 18'h4);
      end
      rst = 1'b0;
      #1;
      check("abort_ready", ready, 1);
      check("abort_we_n_off", SRAM_WE_N, 1);
      check("abort_addr_zero", SRAM_ADDR, 0);
      check("abort_rdata_zero", rdata, 0);
      check("abort_state", dbg_state, 0);
      last_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      v = mk(0, 1, 1032, 32'hFFFFFFFF, 32'h11115555);
      run_access(v, v);

      // Idle: ready high, no strobe, bus released; model also released.
      @(posedge clk); #1;
      sram_model_en = 1'b0;
      wdata   = 32'hFFFFFFFF;
      address = 1024;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("idle_ready", ready, 1);
         check("idle_we_n", SRAM_WE_N, 1);
         check("idle_dq_released", SRAM_DQ === 16'hFFFF, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
